// File: rtl/key_led_ctrl.sv
// rtl/key_led_ctrl.sv - push-button LED mode controller: sync, debounce, 4-mode FSM, blink generator
// Optional long-press force-OFF is enabled with `define LONG_PRESS_EN.
module key_led_ctrl #(
    parameter int unsigned DEB_CNT  = 1_000_000,
    parameter int unsigned SLOW_CNT = 25_000_000,
    parameter int unsigned FAST_CNT = 5_000_000,
    parameter int unsigned LONG_CNT = 100_000_000
) (
    input  logic       sys_clock,
    input  logic       sys_rst_n,
    input  logic       key_in,
    output logic       led_out,
    output logic [1:0] mode,
    output logic       press_pulse
);

    typedef enum logic [1:0] {
        OFF        = 2'd0,
        ON         = 2'd1,
        BLINK_SLOW = 2'd2,
        BLINK_FAST = 2'd3
    } mode_t;

    localparam logic [31:0] DEB_LAST  = 32'(DEB_CNT - 1);
    localparam logic [31:0] SLOW_LAST = 32'(SLOW_CNT - 1);
    localparam logic [31:0] FAST_LAST = 32'(FAST_CNT - 1);

    if (DEB_CNT < 2 || SLOW_CNT < 2 || FAST_CNT < 2 || LONG_CNT < 2) begin : g_param_check
        $error("key_led_ctrl: all count parameters must be >= 2");
    end

    mode_t       state_q;
    mode_t       state_d;
    logic [1:0]  sync_q;
    logic        key_sync;
    logic        key_stable;
    logic        key_stable_d;
    logic [31:0] deb_cnt;
    logic [31:0] blk_cnt;
    logic [31:0] half_last;
    logic        blk_phase;
    logic        mode_chg;
    logic        long_fire;

    assign key_sync = sync_q[1];
    assign mode     = state_q;

    // A differing sample must persist DEB_CNT cycles in a row before it is accepted.
    always_ff @(posedge sys_clock or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            sync_q       <= 2'b11;
            deb_cnt      <= '0;
            key_stable   <= 1'b1;
            key_stable_d <= 1'b1;
            press_pulse  <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], key_in};
            if (key_sync != key_stable) begin
                if (deb_cnt == DEB_LAST) begin
                    key_stable <= key_sync;
                    deb_cnt    <= '0;
                end else begin
                    deb_cnt <= deb_cnt + 32'd1;
                end
            end else begin
                deb_cnt <= '0;
            end
            key_stable_d <= key_stable;
            press_pulse  <= key_stable_d & ~key_stable;
        end
    end

`ifdef LONG_PRESS_EN
    localparam logic [31:0] LONG_LAST = 32'(LONG_CNT - 1);
    localparam logic [31:0] LONG_SAT  = 32'(LONG_CNT);
    logic [31:0] hold_cnt;

    // Saturating one past the trigger value makes the forced OFF fire once per press.
    always_ff @(posedge sys_clock or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            hold_cnt <= '0;
        end else if (key_stable) begin
            hold_cnt <= '0;
        end else if (hold_cnt != LONG_SAT) begin
            hold_cnt <= hold_cnt + 32'd1;
        end
    end

    assign long_fire = ~key_stable & (hold_cnt == LONG_LAST);
`else
    assign long_fire = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        if (press_pulse) begin
            case (state_q)
                OFF:        state_d = ON;
                ON:         state_d = BLINK_SLOW;
                BLINK_SLOW: state_d = BLINK_FAST;
                BLINK_FAST: state_d = OFF;
                default:    state_d = OFF;
            endcase
        end
        if (long_fire) begin
            state_d = OFF;
        end
        mode_chg  = (state_d != state_q);
        half_last = (state_q == BLINK_SLOW) ? SLOW_LAST : FAST_LAST;
    end

    // blk_phase is the blink level one cycle ahead; led_out follows mode and phase a cycle later.
    always_ff @(posedge sys_clock or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q   <= OFF;
            blk_cnt   <= '0;
            blk_phase <= 1'b0;
            led_out   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (mode_chg) begin
                blk_cnt   <= '0;
                blk_phase <= 1'b1;
            end else if (state_q == BLINK_SLOW || state_q == BLINK_FAST) begin
                if (blk_cnt == half_last) begin
                    blk_cnt   <= '0;
                    blk_phase <= ~blk_phase;
                end else begin
                    blk_cnt <= blk_cnt + 32'd1;
                end
            end else begin
                blk_cnt <= '0;
            end
            case (state_q)
                OFF:     led_out <= 1'b0;
                ON:      led_out <= 1'b1;
                default: led_out <= blk_phase;
            endcase
        end
    end

endmodule

// File: tb/tb_key_led_ctrl.sv
// tb/tb_key_led_ctrl.sv - randomized and directed bench for key_led_ctrl against a behavioural model
module tb_key_led_ctrl;

    localparam int DEB  = 4;
    localparam int SLOW = 8;
    localparam int FAST = 2;
    localparam int LONG = 32;

    logic       sys_clock;
    logic       sys_rst_n;
    logic       key_in;
    logic       led_out;
    logic [1:0] mode;
    logic       press_pulse;

    key_led_ctrl #(
        .DEB_CNT (DEB),
        .SLOW_CNT(SLOW),
        .FAST_CNT(FAST),
        .LONG_CNT(LONG)
    ) dut (
        .sys_clock  (sys_clock),
        .sys_rst_n  (sys_rst_n),
        .key_in     (key_in),
        .led_out    (led_out),
        .mode       (mode),
        .press_pulse(press_pulse)
    );

    initial sys_clock = 1'b0;
    always #5 sys_clock = ~sys_clock;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    // Model: edge-indexed history of the key, run length of disagreement, press times, mode entry time.
    bit m_s1, m_s2, m_st, m_led, m_pulse;
    int m_run, m_fall, m_mode, m_entry;
`ifdef LONG_PRESS_EN
    int m_held;
`endif

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic bit led_for(input int md, input int n, input int entry);
        case (md)
            0:       return 1'b0;
            1:       return 1'b1;
            2:       return (((n - entry - 1) / SLOW) % 2) == 0;
            default: return (((n - entry - 1) / FAST) % 2) == 0;
        endcase
    endfunction

    task automatic model_reset();
        m_s1    = 1'b1;
        m_s2    = 1'b1;
        m_st    = 1'b1;
        m_run   = 0;
        m_fall  = -10;
        m_mode  = 0;
        m_entry = cyc;
        m_led   = 1'b0;
        m_pulse = 1'b0;
`ifdef LONG_PRESS_EN
        m_held  = 0;
`endif
    endtask

    task automatic model_step();
        bit new_led, new_pulse;
        int new_mode;
        cyc++;
        if (!sys_rst_n) begin
            model_reset();
            return;
        end
        new_led  = led_for(m_mode, cyc, m_entry);
        new_mode = m_mode;
        if (m_pulse) new_mode = (m_mode + 1) % 4;
`ifdef LONG_PRESS_EN
        if (!m_st) begin
            m_held++;
            if (m_held == LONG) new_mode = 0;
        end else begin
            m_held = 0;
        end
`endif
        new_pulse = (m_fall == cyc - 1);
        if (m_s2 != m_st) begin
            m_run++;
            if (m_run == DEB) begin
                m_st  = m_s2;
                m_run = 0;
                if (!m_st) m_fall = cyc;
            end
        end else begin
            m_run = 0;
        end
        m_s2 = m_s1;
        m_s1 = key_in;
        if (new_mode != m_mode) m_entry = cyc;
        m_mode  = new_mode;
        m_led   = new_led;
        m_pulse = new_pulse;
    endtask

    task automatic tick();
        @(posedge sys_clock);
        model_step();
        #1;
        check("press_pulse", 32'(press_pulse), 32'(m_pulse));
        check("mode", 32'(mode), 32'(m_mode));
        check("led_out", 32'(led_out), 32'(m_led));
    endtask

    task automatic do_reset();
        sys_rst_n = 1'b0;
        #2;
        check("rst_led", 32'(led_out), 32'd0);
        check("rst_mode", 32'(mode), 32'd0);
        check("rst_pulse", 32'(press_pulse), 32'd0);
        model_reset();
        repeat (2) tick();
        sys_rst_n = 1'b1;
    endtask

    task automatic press(input int hold, input int gap);
        key_in = 1'b0;
        repeat (hold) tick();
        key_in = 1'b1;
        repeat (gap) tick();
    endtask

    task automatic measure_low_run(input string name, input int want);
        int  guard = 0;
        int  len   = 0;
        bit  prev;
        do begin
            prev = led_out;
            tick();
            guard++;
        end while (!(prev && !led_out) && guard < 60);
        while (!led_out && guard < 120) begin
            len++;
            tick();
            guard++;
        end
        check(name, 32'(len), 32'(want));
    endtask

    initial begin
        int first_pulse, pulses, changes, guard, e2;
        bit saw2;

        sys_rst_n = 1'b0;
        key_in    = 1'b1;
        model_reset();
        repeat (3) tick();
        sys_rst_n = 1'b1;
        repeat (5) tick();

        // Reset mid-blink, then idle.
        press(10, 20);
        press(10, 20);
        check("pre_reset_mode", 32'(mode), 32'd2);
        repeat (5) tick();
        do_reset();
        changes = 0;
        repeat (100) begin
            tick();
            if (mode != 2'd0 || led_out || press_pulse) changes++;
        end
        check("idle_after_reset", 32'(changes), 32'd0);

        // Three-cycle glitch must not register.
        pulses = 0;
        key_in = 1'b0;
        repeat (3) begin tick(); if (press_pulse) pulses++; end
        key_in = 1'b1;
        repeat (20) begin tick(); if (press_pulse) pulses++; end
        check("glitch_pulses", 32'(pulses), 32'd0);
        check("glitch_mode", 32'(mode), 32'd0);

        // Clean press: pulse on the 7th edge after key_in falls, single pulse.
        first_pulse = 0;
        pulses      = 0;
        key_in      = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (press_pulse) begin
                pulses++;
                if (first_pulse == 0) first_pulse = i;
            end
        end
        check("press_latency", 32'(first_pulse), 32'd7);
        check("press_count", 32'(pulses), 32'd1);
        check("press_mode", 32'(mode), 32'd1);
        check("press_led", 32'(led_out), 32'd1);
        key_in = 1'b1;
        repeat (20) tick();

        // Walk through blink modes.
        press(10, 20);
        check("mode_slow", 32'(mode), 32'd2);
        measure_low_run("slow_half", SLOW);
        press(10, 20);
        check("mode_fast", 32'(mode), 32'd3);
        measure_low_run("fast_half", FAST);
        press(10, 20);
        check("mode_wrap_off", 32'(mode), 32'd0);
        check("led_wrap_off", 32'(led_out), 32'd0);

        // Mode change landing on a blink wrap edge.
        press(10, 20);
        press(10, 20);
        e2    = m_entry;
        guard = 0;
        while (((cyc - e2) % SLOW) != 0 && guard < 20) begin
            tick();
            guard++;
        end
        key_in = 1'b0;
        repeat (8) tick();
        check("wrap_press_mode", 32'(mode), 32'd3);
        tick();
        check("wrap_press_led", 32'(led_out), 32'd1);
        repeat (9) tick();
        key_in = 1'b1;
        repeat (20) tick();

        // Long hold from ON.
        press(10, 20);
        press(10, 20);
        check("hold_start_mode", 32'(mode), 32'd1);
        saw2   = 1'b0;
        key_in = 1'b0;
        repeat (40) begin tick(); if (mode == 2'd2) saw2 = 1'b1; end
        key_in = 1'b1;
        repeat (20) tick();
        check("hold_saw_slow", 32'(saw2), 32'd1);
`ifdef LONG_PRESS_EN
        check("hold_end_mode", 32'(mode), 32'd0);
`else
        check("hold_end_mode", 32'(mode), 32'd2);
`endif

        // Random key activity with occasional asynchronous resets.
        for (int seg = 0; seg < 300; seg++) begin
            if ($urandom_range(0, 49) == 0) begin
                do_reset();
            end else begin
                key_in = 1'($urandom_range(0, 1));
                repeat ($urandom_range(1, 12)) tick();
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
